riscv_data_mem_resp: RTL and testbench
======================================

// Module: riscv_data_mem_resp
// PURPOSE
//   Responder end of the data_bif bus: a word-organised, byte-maskable data RAM that
//   answers requests from the EX-stage load/store unit.
//   - Sits on the data_bif port of riscv_ex_pipe in simulation and FPGA builds.
//   - Inserts a configurable, optionally pseudo-random, number of wait states so the
//     EX stall paths get exercised.
// PARAMETERS
//   ADDR_W       12   word-address width; DEPTH = 2**ADDR_W 32-bit words
//   WAIT_CYCLES  1    fixed wait states between request acceptance and ack (0..15)
//   RAND_STALL   0    1: add 0..3 extra wait states per transfer, taken from LFSR[1:0]
//   LFSR_SEED    16'hACE1  reset value of the 16-bit stall LFSR (must be non-zero)
//   INIT_FILE    ""   if non-empty, $readmemh into the array at time 0
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous reset, active-high
//   data_bif_req    in   1   request valid; held with addr/rnw/wmask/wdata until ack
//   data_bif_addr   in   32  byte address; word index = addr[ADDR_W+1:2]
//   data_bif_rnw    in   1   1 = read, 0 = write
//   data_bif_wmask  in   4   byte enables for writes, bit n = byte lane n (bits 8n+7:8n)
//   data_bif_wdata  in   32  write data, lane-aligned
//   data_bif_ack    out  1   one-cycle completion pulse (registered)
//   data_bif_rdata  out  32  read word; valid only while ack=1, else 32'h0
// BEHAVIOUR
//   Reset (async assert, sync release): state=IDLE, ack=0, rdata=0, wait counter=0,
//     LFSR=LFSR_SEED. Array contents are NOT reset.
//   FSM
//     IDLE: if req=1, latch rnw/addr/wmask/wdata and load
//       cnt = WAIT_CYCLES + (RAND_STALL ? LFSR[1:0] : 0).
//       Go to ACK if cnt==0, else to WAIT. The LFSR advances once per accepted request
//       (taps 16,14,13,11).
//     WAIT: cnt decrements each cycle; go to ACK when cnt reaches 1.
//     ACK: ack=1 for exactly one cycle, then back to IDLE unconditionally.
//   Latency: req first high in cycle 0 -> ack high in cycle 1+total_wait.
//     Minimum 1 cycle; one transfer per 2+total_wait cycles.
//   Array access happens on the edge entering ACK:
//     - write: byte lane n updated iff wmask[n]=1.
//     - read: rdata <= array[idx]; a full word is returned and wmask is ignored.
//   Back-to-back: req may stay high after ack. The cycle following ack is IDLE, which
//     samples req as a NEW request. Write then read of the same word returns new data.
//   Address rules:
//     - addr[1:0] ignored (initiator aligns; lanes come from wmask).
//     - addr bits above ADDR_W+1 ignored, so addresses alias modulo 4*DEPTH bytes.
//   Write with wmask=4'b0000: completes with ack and leaves the array unchanged.
//   req dropped while in WAIT (protocol violation): abort to IDLE next edge.
//     No ack, no array write. $display("ERROR: data_bif req dropped") in simulation.
//   Changes to inputs while waiting are ignored; latched values are used.
//   Reset mid-transfer: ack drops immediately and the FSM returns to IDLE. A write not
//     yet at the ACK edge is never performed.
// TESTING
//   1 WAIT_CYCLES=1: write addr=0x10, wdata=0xDEADBEEF, wmask=0xF
//       -> ack in cycle 2; then read 0x10 -> rdata=0xDEADBEEF with ack in cycle 2.
//   2 Byte lanes: word 0x20=0x11223344, then write wdata=0xAABBCCDD wmask=4'b0101
//       -> read returns 0x11BB33DD.
//   3 Aliasing, ADDR_W=12: write 0x0000_4004 = 0x5A5A5A5A -> read 0x0000_0004
//       returns 0x5A5A5A5A.
//   4 Back-to-back, WAIT_CYCLES=0, req held high for 4 transfers
//       -> ack pattern 0101_0101; rdata=0 in every non-ack cycle.
//   5 Abort: WAIT_CYCLES=3, write 0x30 with req dropped in cycle 2
//       -> no ack, error printed; later read of 0x30 returns the prior value.
//   6 RAND_STALL=1, 200 random R/W vs scoreboard model
//       -> all reads match; ack latency always in 1+WAIT..4+WAIT.
//       Also assert rst mid-WAIT -> ack=0 at once and the pending write is absent.

Source files
------------

// File: rtl/riscv_data_mem_resp.sv
// riscv_data_mem_resp
// Responder end of the data_bif bus: word-organised, byte-maskable data RAM.
// Wait states are programmable and can be randomised per transfer with an LFSR,
// so the load/store stall paths in the EX stage get exercised.
module riscv_data_mem_resp #(
    parameter int          ADDR_W      = 12,
    parameter int          WAIT_CYCLES = 1,
    parameter int          RAND_STALL  = 0,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        data_bif_req,
    input  logic [31:0] data_bif_addr,
    input  logic        data_bif_rnw,
    input  logic [3:0]  data_bif_wmask,
    input  logic [31:0] data_bif_wdata,
    output logic        data_bif_ack,
    output logic [31:0] data_bif_rdata
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t              state;
    logic [4:0]          cnt;
    logic [15:0]         lfsr;
    logic                lat_rnw;
    logic [ADDR_W-1:0]   lat_idx;
    logic [3:0]          lat_wmask;
    logic [31:0]         lat_wdata;

    logic [31:0]         mem [DEPTH];

    logic                accept;
    logic [4:0]          load_cnt;
    logic                enter_ack;
    logic                lfsr_fb;
    logic                acc_rnw;
    logic [ADDR_W-1:0]   acc_idx;
    logic [3:0]          acc_wmask;
    logic [31:0]         acc_wdata;

    // Byte-offset bits and bits above the array size do not select anything.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{data_bif_addr[31:ADDR_W+2], data_bif_addr[1:0]};

    // Next-state decode. A zero-wait transfer hits the array on the accepting
    // edge using the live bus; otherwise the latched copy is used.
    always_comb begin
        accept    = (state == IDLE) && data_bif_req;
        load_cnt  = 5'(WAIT_CYCLES) + ((RAND_STALL != 0) ? {3'b000, lfsr[1:0]} : 5'd0);
        lfsr_fb   = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];
        enter_ack = (accept && (load_cnt == 5'd0)) ||
                    ((state == WAIT) && data_bif_req && (cnt == 5'd1));
        if (state == IDLE) begin
            acc_rnw   = data_bif_rnw;
            acc_idx   = data_bif_addr[ADDR_W+1:2];
            acc_wmask = data_bif_wmask;
            acc_wdata = data_bif_wdata;
        end else begin
            acc_rnw   = lat_rnw;
            acc_idx   = lat_idx;
            acc_wmask = lat_wmask;
            acc_wdata = lat_wdata;
        end
    end

    // Control FSM with registered ack/rdata; rdata is forced to zero outside ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 5'd0;
            lfsr           <= LFSR_SEED;
            lat_rnw        <= 1'b1;
            lat_idx        <= '0;
            lat_wmask      <= 4'h0;
            lat_wdata      <= 32'h0;
            data_bif_ack   <= 1'b0;
            data_bif_rdata <= 32'h0;
        end else begin
            data_bif_ack   <= enter_ack;
            data_bif_rdata <= (enter_ack && acc_rnw) ? mem[acc_idx] : 32'h0;
            case (state)
                IDLE: begin
                    if (data_bif_req) begin
                        lat_rnw   <= data_bif_rnw;
                        lat_idx   <= data_bif_addr[ADDR_W+1:2];
                        lat_wmask <= data_bif_wmask;
                        lat_wdata <= data_bif_wdata;
                        lfsr      <= {lfsr[14:0], lfsr_fb};
                        cnt       <= load_cnt;
                        state     <= (load_cnt == 5'd0) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    // A dropped request abandons the transfer without touching the array.
                    if (!data_bif_req) begin
                        cnt   <= 5'd0;
                        state <= IDLE;
                    end else if (cnt == 5'd1) begin
                        cnt   <= 5'd0;
                        state <= ACK;
                    end else begin
                        cnt <= cnt - 5'd1;
                    end
                end
                ACK:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Array write on the edge entering ACK; only enabled byte lanes change.
    always_ff @(posedge clk) begin
        if (!rst && enter_ack && !acc_rnw) begin
            for (int n = 0; n < 4; n++) begin
                if (acc_wmask[n]) mem[acc_idx][8*n +: 8] <= acc_wdata[8*n +: 8];
            end
        end
    end

`ifndef SYNTHESIS
    // Flag initiators that withdraw a request before it is acknowledged.
    always @(posedge clk) begin
        if (!rst && state == WAIT && !data_bif_req) $display("ERROR: data_bif req dropped");
    end
`endif

endmodule

// File: tb/tb_riscv_data_mem_resp.sv
// Directed bench for riscv_data_mem_resp. Three instances share clk/rst:
//   0: WAIT_CYCLES=1, 1: WAIT_CYCLES=0, 2: WAIT_CYCLES=3 with random stalls.
module tb_riscv_data_mem_resp;

    logic        clk = 1'b0;
    logic        rst;
    logic        req   [3];
    logic [31:0] addr  [3];
    logic        rnw   [3];
    logic [3:0]  wmask [3];
    logic [31:0] wdata [3];
    logic        ack   [3];
    logic [31:0] rdata [3];

    int cmp  = 0;
    int errs = 0;

    logic [31:0] model [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        riscv_data_mem_resp #(
            .ADDR_W(12),
            .WAIT_CYCLES(g == 0 ? 1 : (g == 1 ? 0 : 3)),
            .RAND_STALL(g == 2 ? 1 : 0)
        ) u_dut (
            .clk(clk),
            .rst(rst),
            .data_bif_req(req[g]),
            .data_bif_addr(addr[g]),
            .data_bif_rnw(rnw[g]),
            .data_bif_wmask(wmask[g]),
            .data_bif_wdata(wdata[g]),
            .data_bif_ack(ack[g]),
            .data_bif_rdata(rdata[g])
        );
    end

    // One transfer starting just after a rising edge; lat = cycle index of ack.
    task automatic xfer(input int s, input logic r, input logic [31:0] a, input logic [3:0] m,
                        input logic [31:0] d, output logic [31:0] rd, output int lat);
        req[s] = 1'b1; rnw[s] = r; addr[s] = a; wmask[s] = m; wdata[s] = d;
        lat = 0; rd = 32'h0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ack[s]) begin rd = rdata[s]; break; end
            lat++;
            @(posedge clk); #1;
        end
        req[s] = 1'b0;
        @(posedge clk); #1;
        if (lat >= 40) begin
            cmp++; errs++;
            $display("FAIL xfer_timeout inst=%0d addr=%h: no ack within 40 cycles", s, a);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            cmp++;
            if (ack[s] !== 1'b0) begin errs++; $display("FAIL reset_ack inst=%0d got=%b exp=0", s, ack[s]); end
            cmp++;
            if (rdata[s] !== 32'h0) begin errs++; $display("FAIL reset_rdata inst=%0d got=%h exp=0", s, rdata[s]); end
        end
    endtask

    task automatic test_basic();
        logic [31:0] rd; int lat;
        xfer(0, 1'b0, 32'h10, 4'hF, 32'hDEADBEEF, rd, lat);
        cmp++; if (lat !== 2) begin errs++; $display("FAIL basic_wr_lat got=%0d exp=2", lat); end
        xfer(0, 1'b1, 32'h10, 4'h0, 32'h0, rd, lat);
        cmp++; if (lat !== 2) begin errs++; $display("FAIL basic_rd_lat got=%0d exp=2", lat); end
        cmp++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL basic_rd_data got=%h exp=deadbeef", rd); end
        // zero mask: acknowledged, array untouched
        xfer(0, 1'b0, 32'h10, 4'h0, 32'h01234567, rd, lat);
        cmp++; if (lat !== 2) begin errs++; $display("FAIL mask0_lat got=%0d exp=2", lat); end
        xfer(0, 1'b1, 32'h10, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== 32'hDEADBEEF) begin errs++; $display("FAIL mask0_data got=%h exp=deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd; int lat;
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h11223344, rd, lat);
        xfer(0, 1'b0, 32'h20, 4'b0101, 32'hAABBCCDD, rd, lat);
        xfer(0, 1'b1, 32'h20, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL byte_lanes got=%h exp=11bb33dd", rd); end
        // low address bits do not shift lanes
        xfer(0, 1'b1, 32'h23, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== 32'h11BB33DD) begin errs++; $display("FAIL addr_lowbits got=%h exp=11bb33dd", rd); end
    endtask

    task automatic test_alias();
        logic [31:0] rd; int lat;
        xfer(0, 1'b0, 32'h0000_4004, 4'hF, 32'h5A5A5A5A, rd, lat);
        xfer(0, 1'b1, 32'h0000_0004, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== 32'h5A5A5A5A) begin errs++; $display("FAIL alias got=%h exp=5a5a5a5a", rd); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd; int lat; int idx;
        logic [31:0] exp_d [4];
        for (int i = 0; i < 4; i++) begin
            exp_d[i] = 32'hA000_0000 + 32'(i * 17);
            xfer(1, 1'b0, 32'h40 + 32'(4 * i), 4'hF, exp_d[i], rd, lat);
            cmp++; if (lat !== 1) begin errs++; $display("FAIL b2b_wr_lat i=%0d got=%0d exp=1", i, lat); end
        end
        idx = 0;
        req[1] = 1'b1; rnw[1] = 1'b1; addr[1] = 32'h40; wmask[1] = 4'h0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            cmp++;
            if (ack[1] !== 1'(c % 2)) begin errs++; $display("FAIL b2b_ack cycle=%0d got=%b exp=%0d", c, ack[1], c % 2); end
            if (c % 2 == 1) begin
                cmp++;
                if (rdata[1] !== exp_d[idx]) begin errs++; $display("FAIL b2b_rdata n=%0d got=%h exp=%h", idx, rdata[1], exp_d[idx]); end
                idx++;
                if (idx == 4) req[1] = 1'b0;
                else addr[1] = 32'h40 + 32'(4 * idx);
            end else begin
                cmp++;
                if (rdata[1] !== 32'h0) begin errs++; $display("FAIL b2b_idle_rdata cycle=%0d got=%h exp=0", c, rdata[1]); end
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd; int lat; int acks;
        xfer(2, 1'b0, 32'h30, 4'hF, 32'h12345678, rd, lat);
        req[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 32'h30; wmask[2] = 4'hF; wdata[2] = 32'hFFFFFFFF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        req[2] = 1'b0;  // cycle 2, still waiting
        acks = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (ack[2]) acks++;
            @(posedge clk); #1;
        end
        cmp++; if (acks !== 0) begin errs++; $display("FAIL abort_ack got=%0d acks exp=0", acks); end
        xfer(2, 1'b1, 32'h30, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== 32'h12345678) begin errs++; $display("FAIL abort_data got=%h exp=12345678", rd); end
    endtask

    task automatic test_rand();
        logic [31:0] rd; int lat; int lmin; int lmax;
        logic r; logic [3:0] m; logic [31:0] d; int w; logic [31:0] a;
        lmin = 99; lmax = -1;
        for (int i = 0; i < 16; i++) begin
            model[i] = $urandom;
            xfer(2, 1'b0, 32'(4 * i), 4'hF, model[i], rd, lat);
        end
        for (int t = 0; t < 200; t++) begin
            r = 1'($urandom_range(0, 1));
            w = $urandom_range(0, 15);
            a = 32'(4 * w) | (32'($urandom_range(0, 3)) << 14) | 32'($urandom_range(0, 3));
            m = 4'($urandom_range(0, 15));
            d = $urandom;
            xfer(2, r, a, m, d, rd, lat);
            if (lat < lmin) lmin = lat;
            if (lat > lmax) lmax = lat;
            cmp++;
            if (lat < 4 || lat > 7) begin errs++; $display("FAIL rand_lat t=%0d got=%0d exp=4..7", t, lat); end
            if (r) begin
                cmp++;
                if (rd !== model[w]) begin errs++; $display("FAIL rand_rdata t=%0d w=%0d got=%h exp=%h", t, w, rd, model[w]); end
            end else begin
                for (int n = 0; n < 4; n++) if (m[n]) model[w][8*n +: 8] = d[8*n +: 8];
            end
        end
        cmp++;
        if (lmax <= lmin) begin errs++; $display("FAIL rand_spread got min=%0d max=%0d exp max>min", lmin, lmax); end
    endtask

    task automatic test_rst_mid();
        logic [31:0] rd; int lat; int seen;
        // reset while waiting: the write must never land
        req[2] = 1'b1; rnw[2] = 1'b0; addr[2] = 32'h14; wmask[2] = 4'hF; wdata[2] = 32'hCAFEF00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1; req[2] = 1'b0;
        #1;
        cmp++; if (ack[2] !== 1'b0) begin errs++; $display("FAIL rst_wait_ack got=%b exp=0", ack[2]); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        xfer(2, 1'b1, 32'h14, 4'h0, 32'h0, rd, lat);
        cmp++; if (rd !== model[5]) begin errs++; $display("FAIL rst_wait_data got=%h exp=%h", rd, model[5]); end
        // reset during the ack cycle: ack and rdata drop without a clock edge
        req[0] = 1'b1; rnw[0] = 1'b1; addr[0] = 32'h10; wmask[0] = 4'h0;
        seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            @(negedge clk);
            if (ack[0]) seen = 1;
            else begin @(posedge clk); #1; end
        end
        cmp++; if (seen !== 1) begin errs++; $display("FAIL rst_ack_seen got=%0d exp=1", seen); end
        rst = 1'b1; req[0] = 1'b0;
        #1;
        cmp++; if (ack[0] !== 1'b0) begin errs++; $display("FAIL rst_ack_drop got=%b exp=0", ack[0]); end
        cmp++; if (rdata[0] !== 32'h0) begin errs++; $display("FAIL rst_rdata_drop got=%h exp=0", rdata[0]); end
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        rst = 1'b1;
        for (int s = 0; s < 3; s++) begin
            req[s] = 1'b0; addr[s] = 32'h0; rnw[s] = 1'b1; wmask[s] = 4'h0; wdata[s] = 32'h0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_basic();
        test_byte_lanes();
        test_alias();
        test_back_to_back();
        test_abort();
        test_rand();
        test_rst_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule
